// File: rtl/imem_loader.sv
// Streams words into instruction memory from address 0 with the core held in reset; writes land one cycle after acceptance.
// s_ready_o is high only in LOAD and never depends on s_valid_i; the core is released the cycle after done_o.
module imem_loader #(
  parameter int DATAWIDTH = 32,
  parameter int NUMWORDS  = 32,
  parameter int ADDRWIDTH = $clog2(NUMWORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDRWIDTH:0]   len_i,
  input  logic                 s_valid_i,
  input  logic [DATAWIDTH-1:0] s_data_i,
  output logic                 s_ready_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_waddr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  output logic                 cpu_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATAWIDTH-1:0] checksum_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RUN} state_t;

  localparam logic [ADDRWIDTH:0] LEN_MAX = (ADDRWIDTH+1)'(NUMWORDS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDRWIDTH:0]   r_len;
  logic [ADDRWIDTH:0]   r_cnt;
  logic [ADDRWIDTH:0]   w_len_clamped;
  logic [ADDRWIDTH:0]   w_cnt_inc;
  logic                 w_start;
  logic                 w_accept;
  logic                 r_we;
  logic [ADDRWIDTH-1:0] r_waddr;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [DATAWIDTH-1:0] r_checksum;

  // start is only honoured while no load is in flight
  assign w_start       = start_i && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_accept      = s_valid_i && (r_state == S_LOAD);
  assign w_len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign w_cnt_inc     = r_cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_start) begin
          w_state_nxt = (w_len_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && (w_cnt_inc == r_len)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = (r_state == S_LOAD);
    busy_o    = (r_state == S_LOAD);
    done_o    = (r_state == S_DONE);
    cpu_rst_o = (r_state != S_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_checksum <= '0;
    end else begin
      r_we <= w_accept;
      if (w_start) begin
        r_len      <= w_len_clamped;
        r_cnt      <= '0;
        r_checksum <= '0;
      end else if (w_accept) begin
        r_waddr    <= r_cnt[ADDRWIDTH-1:0];
        r_wdata    <= s_data_i;
        r_checksum <= r_checksum + s_data_i;
        r_cnt      <= w_cnt_inc;
      end
    end
  end

  assign mem_we_o    = r_we;
  assign mem_waddr_o = r_waddr;
  assign mem_wdata_o = r_wdata;
  assign checksum_o  = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle-by-cycle expectations relative to the start_i cycle.
module tb_imem_loader;
  localparam int DW = 32;
  localparam int NW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          s_valid_i;
  logic [DW-1:0] s_data_i;
  logic          s_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_waddr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          cpu_rst_o;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] checksum_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_loader #(.DATAWIDTH(DW), .NUMWORDS(NW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .s_valid_i  (s_valid_i),
    .s_data_i   (s_data_i),
    .s_ready_o  (s_ready_o),
    .mem_we_o   (mem_we_o),
    .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o),
    .cpu_rst_o  (cpu_rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .checksum_o (checksum_o)
  );

  // flags order: cpu_rst, s_ready, mem_we, busy, done
  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; len_i = '0; s_valid_i = 1'b0; s_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o, mem_waddr_o, mem_wdata_o, checksum_o} !==
        {5'b10000, 5'd0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_values got flags=%b cs=%h", {cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o}, checksum_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({cpu_rst_o, s_ready_o, mem_we_o, checksum_o} !== {3'b100, 32'd0}) begin
        failures++;
        $display("FAIL idle c=%0d got flags=%b cs=%h exp flags=100 cs=0", c, {cpu_rst_o, s_ready_o, mem_we_o}, checksum_o);
      end
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] words [4];
    logic [DW-1:0] cs;
    logic          exp_we;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    cs = '0;
    start_i = 1'b1; len_i = 6'd4; s_valid_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      exp_we = (c >= 2) && (c <= 5);
      if (exp_we) cs = cs + words[c-2];
      checks++;
      if ({cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o} !== {c < 6, c <= 4, exp_we, c <= 4, c == 5}) begin
        failures++;
        $display("FAIL basic_flags c=%0d got=%b exp=%b", c, {cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o},
                 {c < 6, c <= 4, exp_we, c <= 4, c == 5});
      end
      if (exp_we) begin
        checks++;
        if (mem_waddr_o !== AW'(c-2) || mem_wdata_o !== words[c-2]) begin
          failures++;
          $display("FAIL basic_write c=%0d got a=%0d d=%h exp a=%0d d=%h", c, mem_waddr_o, mem_wdata_o, c-2, words[c-2]);
        end
      end
      checks++;
      if (checksum_o !== cs) begin
        failures++;
        $display("FAIL basic_checksum c=%0d got=%h exp=%h", c, checksum_o, cs);
      end
      s_valid_i = (c <= 4);
      s_data_i  = (c <= 4) ? words[c-1] : '0;
    end
    checks++;
    if (cs !== 32'hAA || checksum_o !== 32'hAA) begin
      failures++;
      $display("FAIL basic_final_checksum got=%h exp=000000aa", checksum_o);
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] words [3];
    logic          exp_we;
    int            nwr;
    words[0] = 32'h100; words[1] = 32'h200; words[2] = 32'h300;
    nwr = 0;
    checks++;
    if (cpu_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL gaps_running got cpu_rst=%b exp=0", cpu_rst_o);
    end
    start_i = 1'b1; len_i = 6'd3; s_valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      exp_we = (c == 2) || (c == 4) || (c == 6);
      checks++;
      if ({cpu_rst_o, s_ready_o, mem_we_o, done_o} !== {c <= 6, c <= 5, exp_we, c == 6}) begin
        failures++;
        $display("FAIL gaps_flags c=%0d got=%b exp=%b", c, {cpu_rst_o, s_ready_o, mem_we_o, done_o},
                 {c <= 6, c <= 5, exp_we, c == 6});
      end
      if (mem_we_o === 1'b1) nwr++;
      if (exp_we) begin
        checks++;
        if (mem_waddr_o !== AW'((c-2)/2) || mem_wdata_o !== words[(c-2)/2]) begin
          failures++;
          $display("FAIL gaps_write c=%0d got a=%0d d=%h exp a=%0d", c, mem_waddr_o, mem_wdata_o, (c-2)/2);
        end
      end
      s_valid_i = (c == 1) || (c == 3) || (c == 5);
      s_data_i  = words[((c-1)/2) % 3];
    end
    checks++;
    if (nwr != 3 || checksum_o !== 32'h600) begin
      failures++;
      $display("FAIL gaps_total got writes=%0d cs=%h exp writes=3 cs=00000600", nwr, checksum_o);
    end
  endtask

  task automatic test_len0();
    start_i = 1'b1; len_i = 6'd0; s_valid_i = 1'b1; s_data_i = 32'hDEAD;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      checks++;
      if ({cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o, checksum_o} !== {c == 1, 3'b000, c == 1, 32'd0}) begin
        failures++;
        $display("FAIL len0 c=%0d got flags=%b cs=%h", c, {cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o}, checksum_o);
      end
    end
    s_valid_i = 1'b0;
  endtask

  task automatic test_clamp();
    int nwr;
    int last_addr;
    int done_c;
    nwr = 0; last_addr = -1; done_c = -1;
    start_i = 1'b1; len_i = 6'd40; s_valid_i = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (mem_we_o === 1'b1) begin
        nwr++;
        last_addr = int'(mem_waddr_o);
        checks++;
        if (mem_waddr_o !== AW'(c-2) || mem_wdata_o !== DW'(c-1)) begin
          failures++;
          $display("FAIL clamp_write c=%0d got a=%0d d=%h exp a=%0d", c, mem_waddr_o, mem_wdata_o, c-2);
        end
      end
      if (done_o === 1'b1) done_c = c;
      s_valid_i = 1'b1;
      s_data_i  = DW'(c);
    end
    s_valid_i = 1'b0;
    checks++;
    if (nwr != 32 || last_addr != 31 || done_c != 33 || checksum_o !== 32'd528 || cpu_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL clamp got writes=%0d last=%0d done_c=%0d cs=%h exp 32/31/33/00000210", nwr, last_addr, done_c, checksum_o);
    end
  endtask

  task automatic test_overflow();
    start_i = 1'b1; len_i = 6'd2; s_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (c == 2) begin
        checks++;
        if (checksum_o !== 32'hFFFFFFFF) begin
          failures++;
          $display("FAIL ovf_partial got=%h exp=ffffffff", checksum_o);
        end
      end
      if (c >= 3) begin
        checks++;
        if (checksum_o !== 32'h1 || done_o !== (c == 3)) begin
          failures++;
          $display("FAIL ovf_final c=%0d got cs=%h done=%b exp cs=00000001", c, checksum_o, done_o);
        end
      end
      s_valid_i = (c <= 2);
      s_data_i  = (c == 1) ? 32'hFFFFFFFF : 32'h2;
    end
    s_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; len_i = 6'd5; s_valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      s_valid_i = (c <= 2);
      s_data_i  = (c == 1) ? 32'hA1 : 32'hA2;
    end
    checks++;
    if ({mem_we_o, busy_o, cpu_rst_o} !== 3'b111 || mem_waddr_o !== 5'd1 || checksum_o !== 32'h143) begin
      failures++;
      $display("FAIL rmid_before got we=%b a=%0d cs=%h exp we=1 a=1 cs=00000143", mem_we_o, mem_waddr_o, checksum_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o, mem_waddr_o, mem_wdata_o, checksum_o} !==
        {5'b10000, 5'd0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL rmid_async got flags=%b a=%0d d=%h cs=%h", {cpu_rst_o, s_ready_o, mem_we_o, busy_o, done_o},
               mem_waddr_o, mem_wdata_o, checksum_o);
    end
    s_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cpu_rst_o, s_ready_o, mem_we_o, busy_o} !== 4'b1000) begin
      failures++;
      $display("FAIL rmid_after got=%b exp=1000", {cpu_rst_o, s_ready_o, mem_we_o, busy_o});
    end
  endtask

  task automatic test_start_in_load();
    logic exp_we;
    start_i = 1'b1; len_i = 6'd2; s_valid_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      exp_we = (c == 3) || (c == 4);
      checks++;
      if ({cpu_rst_o, s_ready_o, mem_we_o, done_o} !== {c <= 4, c <= 3, exp_we, c == 4}) begin
        failures++;
        $display("FAIL sil_flags c=%0d got=%b exp=%b", c, {cpu_rst_o, s_ready_o, mem_we_o, done_o},
                 {c <= 4, c <= 3, exp_we, c == 4});
      end
      if (exp_we) begin
        checks++;
        if (mem_waddr_o !== AW'(c-3) || mem_wdata_o !== DW'(c+2)) begin
          failures++;
          $display("FAIL sil_write c=%0d got a=%0d d=%h exp a=%0d d=%0d", c, mem_waddr_o, mem_wdata_o, c-3, c+2);
        end
      end
      start_i   = (c == 1) || (c == 4);
      len_i     = (c == 1) ? 6'd5 : 6'd3;
      s_valid_i = (c == 2) || (c == 3);
      s_data_i  = DW'(c + 3);
    end
    checks++;
    if (checksum_o !== 32'd11) begin
      failures++;
      $display("FAIL sil_checksum got=%h exp=0000000b", checksum_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_len0();
    test_clamp();
    test_overflow();
    test_reset_mid();
    test_start_in_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
